// File: rtl/note_seq_if.sv
// note_seq_if: host/config and oscillator-facing signals of the note sequencer.
// master = host/config side, slave = sequencer.
interface note_seq_if #(
  parameter int unsigned STEPS   = 16,
  parameter int unsigned TEMPO_W = 16
);
  localparam int unsigned AW = $clog2(STEPS);

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [11:0]        wr_data;
  logic [AW-1:0]      len;
  logic [TEMPO_W-1:0] step_ticks;
  logic               start;
  logic               stop;
  logic [11:0]        count_max;
  logic               gate;
  logic [AW-1:0]      step;
  logic               busy;
  logic               done;

  modport master (
    output wr_en, wr_addr, wr_data, len, step_ticks, start, stop,
    input  count_max, gate, step, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, step_ticks, start, stop,
    output count_max, gate, step, busy, done
  );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a programmable note table at a programmable
// tempo, driving the oscillator half-period (count_max) and an articulation gate.
// Optional feature macro: NOTE_SEQUENCER_LOOP_EN -- when defined, the pattern
// wraps to step 0 at its end instead of returning to IDLE.
module note_sequencer #(
  parameter int unsigned STEPS   = 16,
  parameter int unsigned TEMPO_W = 16,
  parameter int unsigned GAP     = 16
) (
  input  logic         clk,
  input  logic         rst,
  note_seq_if.slave    bus
);
  localparam int unsigned AW = $clog2(STEPS);
  localparam logic [TEMPO_W-1:0] GAP_T = TEMPO_W'(GAP);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state_q, state_d;
  logic [11:0]        pat_q [STEPS];
  logic [AW-1:0]      step_q, step_d;
  logic [TEMPO_W-1:0] tick_q, tick_d;
  logic [AW-1:0]      len_q, len_d;
  logic [TEMPO_W-1:0] ticks_q, ticks_d;
  logic [11:0]        count_max_q, count_max_d;
  logic               gate_q, gate_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [AW-1:0]      next_step;

  // Pattern RAM: writes land at the edge; a fetch at the same edge sees old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STEPS); i++) pat_q[i] <= '0;
    end else if (bus.wr_en) begin
      pat_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      tick_q      <= '0;
      len_q       <= '0;
      ticks_q     <= '0;
      count_max_q <= '0;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tick_q      <= tick_d;
      len_q       <= len_d;
      ticks_q     <= ticks_d;
      count_max_q <= count_max_d;
      gate_q      <= gate_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign next_step = step_q + AW'(1);

  // Next-state: playback stepping, note fetch, end-of-pattern and gate shaping.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    tick_d      = tick_q;
    len_d       = len_q;
    ticks_d     = ticks_q;
    count_max_d = count_max_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    gate_d      = 1'b0;

    if (bus.stop) begin
      state_d     = IDLE;
      step_d      = '0;
      tick_d      = '0;
      count_max_d = '0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d     = PLAY;
            len_d       = bus.len;
            ticks_d     = bus.step_ticks;
            step_d      = '0;
            tick_d      = '0;
            count_max_d = pat_q[0];
            busy_d      = 1'b1;
          end
        end
        PLAY: begin
          if (tick_q != ticks_q) begin
            tick_d = tick_q + TEMPO_W'(1);
          end else if (step_q != len_q) begin
            step_d      = next_step;
            tick_d      = '0;
            count_max_d = pat_q[next_step];
          end else begin
            done_d = 1'b1;
            step_d = '0;
            tick_d = '0;
`ifdef NOTE_SEQUENCER_LOOP_EN
            count_max_d = pat_q[0];
`else
            state_d     = IDLE;
            count_max_d = '0;
            busy_d      = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Gate drops for the last GAP ticks of a step; short steps have no gap.
    if (state_d == PLAY && count_max_d != '0) begin
      gate_d = !(ticks_d >= GAP_T && tick_d > (ticks_d - GAP_T));
    end
  end

  assign bus.count_max = count_max_q;
  assign bus.gate      = gate_q;
  assign bus.step      = step_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
